// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet RX depacketizer.
// Optional feature macro used by the block: VLAN_STRIP_EN.
package eth_rx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        VLAN    = 3'd2,
        PAYLOAD = 3'd3,
        DROP    = 3'd4
    } state_e;

    localparam int unsigned HDR_LEN    = 14;
    localparam int unsigned VLAN_LEN   = 4;
    localparam logic [15:0] VLAN_TPID  = 16'h8100;
    localparam logic [47:0] BCAST_ADDR = 48'hffff_ffff_ffff;

    // Destination address filter: own address, or broadcast when enabled.
    function automatic logic da_match(input logic [47:0] da,
                                      input logic [47:0] my_addr,
                                      input logic        bcast_en);
        return (da == my_addr) || (bcast_en && (da == BCAST_ADDR));
    endfunction

    // EtherType filter: a required type of zero accepts anything.
    function automatic logic type_match(input logic [15:0] ether_type,
                                        input logic [15:0] required);
        return (required == 16'h0000) || (ether_type == required);
    endfunction

endpackage

// File: rtl/eth_rx_depacketizer_if.sv
// Byte-wide AXI-Stream bundle used on both sides of the RX depacketizer.
interface eth_rx_depacketizer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/eth_rx_skid_buf.sv
// Two-entry AXI-Stream register slice carrying {tuser, tlast, tdata}.
// Both the output side and the upstream tready come straight from flops, so
// the slice breaks the timing path in both directions at full throughput.
module eth_rx_skid_buf #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              axi_tclk_i,
    input  logic              axi_tresetn_i,
    input  logic [DATA_W-1:0] s_tdata_i,
    input  logic              s_tvalid_i,
    input  logic              s_tlast_i,
    input  logic              s_tuser_i,
    output logic              s_tready_o,
    output logic [DATA_W-1:0] m_tdata_o,
    output logic              m_tvalid_o,
    output logic              m_tlast_o,
    output logic              m_tuser_o,
    input  logic              m_tready_i
);

    localparam int unsigned W = DATA_W + 2;

    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         out_vld_q, out_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic         rdy_q, rdy_d;
    logic [W-1:0] in_s;
    logic         in_xfer_s;
    logic         out_free_s;

    // Next-state: refill the output stage from the skid entry first, then from the input.
    always_comb begin
        in_s       = {s_tuser_i, s_tlast_i, s_tdata_i};
        in_xfer_s  = s_tvalid_i && rdy_q;
        out_free_s = !out_vld_q || m_tready_i;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (out_free_s) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (in_xfer_s) begin
                out_d     = in_s;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else begin
            if (in_xfer_s) begin
                skid_d     = in_s;
                skid_vld_d = 1'b1;
            end else begin
                skid_vld_d = skid_vld_q;
            end
        end
        rdy_d = !skid_vld_d;
    end

    // Slice registers; upstream ready stays low while in reset.
    always_ff @(posedge axi_tclk_i or posedge axi_tresetn_i) begin
        if (axi_tresetn_i) begin
            out_q      <= {W{1'b0}};
            skid_q     <= {W{1'b0}};
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign s_tready_o = rdy_q;
    assign m_tvalid_o = out_vld_q;
    assign m_tuser_o  = out_q[W-1];
    assign m_tlast_o  = out_q[W-2];
    assign m_tdata_o  = out_q[DATA_W-1:0];

endmodule

// File: rtl/eth_rx_depacketizer.sv
// Receive-side Ethernet depacketizer: parses DA/SA/EtherType, filters on
// destination address and EtherType, strips the header and forwards the
// payload through a register slice. Captures the sender address and counts
// good and dropped frames.
// Optional feature macro: VLAN_STRIP_EN (strip one 802.1Q tag, report its VID).
module eth_rx_depacketizer
    import eth_rx_pkg::*;
#(
    parameter logic [47:0] MY_ADDR      = 48'h5a01_0203_0405,
    parameter logic        ACCEPT_BCAST = 1'b1,
    parameter logic [15:0] ETHERTYPE    = 16'h0000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 axi_tclk_i,
    input  logic                 axi_tresetn_i,
    input  logic                 enable_i,
    eth_rx_depacketizer_if.slave  rx_axis,
    eth_rx_depacketizer_if.master m_axis,
`ifdef VLAN_STRIP_EN
    output logic [11:0]          vlan_id_o,
`endif
    output logic [47:0]          src_addr_o,
    output logic [15:0]          ethertype_o,
    output logic [CNT_W-1:0]     good_cnt_o,
    output logic [CNT_W-1:0]     drop_cnt_o
);

    localparam logic [4:0]       HDR_LAST_IDX = 5'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
`ifdef VLAN_STRIP_EN
    localparam logic [4:0]       VLAN_LAST_IDX = 5'(HDR_LEN + VLAN_LEN - 1);
`endif

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [103:0]     hdr_q, hdr_d;
    logic [47:0]      src_q, src_d;
    logic [15:0]      type_q, type_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             live_q;
`ifdef VLAN_STRIP_EN
    logic [19:0]      tag_q, tag_d;
    logic [47:0]      sa_q, sa_d;
    logic [11:0]      vlan_q, vlan_d;
    logic [27:0]      tag_full_s;
`endif

    logic [111:0]     hdr_full_s;
    logic [47:0]      da_s;
    logic [47:0]      sa_s;
    logic [15:0]      type_s;
    logic             rx_tready_s;
    logic             rx_xfer_s;
    logic             skid_valid_s;
    logic             skid_ready_s;

    // The header shift register holds bytes 0..12; the incoming byte completes it.
    assign hdr_full_s = {hdr_q, rx_axis.tdata};
    assign da_s       = hdr_full_s[111:64];
    assign sa_s       = hdr_full_s[63:16];
    assign type_s     = hdr_full_s[15:0];
`ifdef VLAN_STRIP_EN
    // {TCI[11:0], inner EtherType} once the last tag byte arrives.
    assign tag_full_s = {tag_q, rx_axis.tdata};
`endif

    // Frame parser FSM: next state, header capture, result registers and counters.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hdr_d        = hdr_q;
        src_d        = src_q;
        type_d       = type_q;
        good_d       = good_q;
        drop_d       = drop_q;
`ifdef VLAN_STRIP_EN
        tag_d        = tag_q;
        sa_d         = sa_q;
        vlan_d       = vlan_q;
`endif
        skid_valid_s = 1'b0;
        if (state_q == PAYLOAD) begin
            rx_tready_s = live_q && skid_ready_s;
        end else begin
            rx_tready_s = live_q;
        end
        rx_xfer_s = rx_axis.tvalid && rx_tready_s;

        case (state_q)
            IDLE: begin
                if (rx_xfer_s) begin
                    hdr_d = hdr_full_s[103:0];
                    cnt_d = 5'd1;
                    if (rx_axis.tlast) begin
                        drop_d = drop_q + CNT_ONE;
                    end else if (enable_i) begin
                        state_d = HDR;
                    end else begin
                        state_d = DROP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                if (rx_xfer_s) begin
                    hdr_d = hdr_full_s[103:0];
                    cnt_d = cnt_q + 5'd1;
                    if (rx_axis.tlast) begin
                        // Runt, including a header with no payload behind it.
                        drop_d  = drop_q + CNT_ONE;
                        state_d = IDLE;
                    end else if (cnt_q == HDR_LAST_IDX) begin
                        if (!da_match(da_s, MY_ADDR, ACCEPT_BCAST)) begin
                            state_d = DROP;
`ifdef VLAN_STRIP_EN
                        end else if (type_s == VLAN_TPID) begin
                            state_d = VLAN;
                            sa_d    = sa_s;
`endif
                        end else if (type_match(type_s, ETHERTYPE)) begin
                            state_d = PAYLOAD;
                            src_d   = sa_s;
                            type_d  = type_s;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        state_d = HDR;
                    end
                end else begin
                    state_d = HDR;
                end
            end
`ifdef VLAN_STRIP_EN
            VLAN: begin
                if (rx_xfer_s) begin
                    tag_d = {tag_q[11:0], rx_axis.tdata};
                    cnt_d = cnt_q + 5'd1;
                    if (rx_axis.tlast) begin
                        drop_d  = drop_q + CNT_ONE;
                        state_d = IDLE;
                    end else if (cnt_q == VLAN_LAST_IDX) begin
                        if (type_match(tag_full_s[15:0], ETHERTYPE)) begin
                            state_d = PAYLOAD;
                            src_d   = sa_q;
                            type_d  = tag_full_s[15:0];
                            vlan_d  = tag_full_s[27:16];
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        state_d = VLAN;
                    end
                end else begin
                    state_d = VLAN;
                end
            end
`endif
            PAYLOAD: begin
                skid_valid_s = rx_axis.tvalid;
                if (rx_xfer_s && rx_axis.tlast) begin
                    state_d = IDLE;
                    if (!rx_axis.tuser) begin
                        good_d = good_q + CNT_ONE;
                    end else begin
                        good_d = good_q;
                    end
                end else begin
                    state_d = PAYLOAD;
                end
            end
            DROP: begin
                if (rx_xfer_s && rx_axis.tlast) begin
                    drop_d  = drop_q + CNT_ONE;
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, header capture, result and counter registers.
    always_ff @(posedge axi_tclk_i or posedge axi_tresetn_i) begin
        if (axi_tresetn_i) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            hdr_q   <= 104'd0;
            src_q   <= 48'd0;
            type_q  <= 16'd0;
            good_q  <= {CNT_W{1'b0}};
            drop_q  <= {CNT_W{1'b0}};
            live_q  <= 1'b0;
`ifdef VLAN_STRIP_EN
            tag_q   <= 20'd0;
            sa_q    <= 48'd0;
            vlan_q  <= 12'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            src_q   <= src_d;
            type_q  <= type_d;
            good_q  <= good_d;
            drop_q  <= drop_d;
            live_q  <= 1'b1;
`ifdef VLAN_STRIP_EN
            tag_q   <= tag_d;
            sa_q    <= sa_d;
            vlan_q  <= vlan_d;
`endif
        end
    end

    eth_rx_skid_buf #(
        .DATA_W (8)
    ) u_skid (
        .axi_tclk_i    (axi_tclk_i),
        .axi_tresetn_i (axi_tresetn_i),
        .s_tdata_i     (rx_axis.tdata),
        .s_tvalid_i    (skid_valid_s),
        .s_tlast_i     (rx_axis.tlast),
        .s_tuser_i     (rx_axis.tuser),
        .s_tready_o    (skid_ready_s),
        .m_tdata_o     (m_axis.tdata),
        .m_tvalid_o    (m_axis.tvalid),
        .m_tlast_o     (m_axis.tlast),
        .m_tuser_o     (m_axis.tuser),
        .m_tready_i    (m_axis.tready)
    );

    assign rx_axis.tready = rx_tready_s;
    assign src_addr_o     = src_q;
    assign ethertype_o    = type_q;
    assign good_cnt_o     = good_q;
    assign drop_cnt_o     = drop_q;
`ifdef VLAN_STRIP_EN
    assign vlan_id_o      = vlan_q;
`endif

endmodule

// File: tb/tb_eth_rx_depacketizer.sv
// Directed bench for eth_rx_depacketizer with a frame-level reference model
// and a per-cycle payload scoreboard.
module tb_eth_rx_depacketizer;

    localparam logic [47:0] MY_A    = 48'h5a0102030405;
    localparam logic [47:0] SA1     = 48'h985aebdb066f;
    localparam logic [47:0] SA2     = 48'h0a1b2c3d4e5f;
    localparam logic [47:0] FOREIGN = 48'hda0102030405;
    localparam logic [47:0] BCAST   = 48'hffffffffffff;
    localparam logic [15:0] T_REQ   = 16'h0800;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;
    always #5 clk = ~clk;

    eth_rx_depacketizer_if rx_if ();
    eth_rx_depacketizer_if m_if ();

    logic [47:0] src;
    logic [15:0] typ;
    logic [15:0] good;
    logic [15:0] drop;
`ifdef VLAN_STRIP_EN
    logic [11:0] vid;
    logic [11:0] m_vid = 12'd0;
`endif

    eth_rx_depacketizer #(.ETHERTYPE(16'h0800)) dut (
        .axi_tclk_i    (clk),
        .axi_tresetn_i (rst),
        .enable_i      (en),
        .rx_axis       (rx_if),
        .m_axis        (m_if),
`ifdef VLAN_STRIP_EN
        .vlan_id_o     (vid),
`endif
        .src_addr_o    (src),
        .ethertype_o   (typ),
        .good_cnt_o    (good),
        .drop_cnt_o    (drop)
    );

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  fr_q[$];
    logic [9:0]  exp_q[$];
    logic [15:0] m_good = 16'd0;
    logic [15:0] m_drop = 16'd0;
    logic [47:0] m_src  = 48'd0;
    logic [15:0] m_type = 16'd0;
    int          pop_cnt = 0;
    logic [9:0]  last_pop = 10'd0;
    int          rdy_low = 0;
    bit          tog_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Build a frame: DA, SA, type, then an incrementing payload.
    task automatic mk(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] t,
                      input int npay, input logic [7:0] start);
        fr_q.delete();
        for (int i = 5; i >= 0; i--) fr_q.push_back(da[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) fr_q.push_back(sa[i*8 +: 8]);
        fr_q.push_back(t[15:8]);
        fr_q.push_back(t[7:0]);
        for (int i = 0; i < npay; i++) fr_q.push_back(start + 8'(i));
    endtask

    // Frame-level model: decide accept/drop from the raw bytes and queue the expected payload.
    task automatic model_frame(input bit fen, input bit err);
        int          n;
        int          hl;
        logic [47:0] da;
        logic [47:0] sa;
        logic [15:0] t;
`ifdef VLAN_STRIP_EN
        logic [15:0] tci;
        bit          tagged;
        tagged = 1'b0;
        tci    = 16'd0;
`endif
        n  = fr_q.size();
        hl = 14;
        if (!fen || n <= 14) begin m_drop++; return; end
        da = {fr_q[0], fr_q[1], fr_q[2], fr_q[3], fr_q[4], fr_q[5]};
        sa = {fr_q[6], fr_q[7], fr_q[8], fr_q[9], fr_q[10], fr_q[11]};
        t  = {fr_q[12], fr_q[13]};
        if (!(da == MY_A || da == BCAST)) begin m_drop++; return; end
`ifdef VLAN_STRIP_EN
        if (t == 16'h8100) begin
            if (n <= 18) begin m_drop++; return; end
            tci    = {fr_q[14], fr_q[15]};
            t      = {fr_q[16], fr_q[17]};
            hl     = 18;
            tagged = 1'b1;
        end
`endif
        if (t != T_REQ) begin m_drop++; return; end
        m_src  = sa;
        m_type = t;
`ifdef VLAN_STRIP_EN
        if (tagged) m_vid = tci[11:0];
`endif
        for (int i = hl; i < n; i++) exp_q.push_back({err && (i == n - 1), i == n - 1, fr_q[i]});
        if (!err) m_good++;
    endtask

    // Drive fr_q onto the RX stream; optionally hit reset before byte abort_at.
    task automatic send(input bit err, input int abort_at);
        int budget;
        bit took;
        for (int i = 0; i < fr_q.size(); i++) begin
            if (i == abort_at) begin
                rx_if.tvalid = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("rst_stream", 128'({m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata, rx_if.tready}), 128'd0);
                chk("rst_counters", 128'({good, drop}), 128'd0);
                chk("rst_sa_type", 128'({src, typ}), 128'd0);
                exp_q.delete();
                m_good = 16'd0; m_drop = 16'd0; m_src = 48'd0; m_type = 16'd0;
                @(negedge clk);
                #2 rst = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            rx_if.tvalid = 1'b1;
            rx_if.tdata  = fr_q[i];
            rx_if.tlast  = (i == fr_q.size() - 1);
            rx_if.tuser  = err && (i == fr_q.size() - 1);
            took   = 1'b0;
            budget = 0;
            while (!took) begin
                @(negedge clk);
                if (!rx_if.tready) rdy_low++;
                took = rx_if.tready;
                @(posedge clk);
                #1;
                budget++;
                if (!took && budget > 200) begin
                    checks++; errors++;
                    $display("FAIL rx_budget: byte %0d not accepted within 200 cycles", i);
                    rx_if.tvalid = 1'b0;
                    return;
                end
            end
        end
        rx_if.tvalid = 1'b0;
        rx_if.tlast  = 1'b0;
        rx_if.tuser  = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 4000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_good"}, 128'(good), 128'(m_good));
        chk({tag, "_drop"}, 128'(drop), 128'(m_drop));
        chk({tag, "_src"},  128'(src),  128'(m_src));
        chk({tag, "_type"}, 128'(typ),  128'(m_type));
    endtask

    // Downstream ready: always 1, or the 1,0,0,1,0,1 pattern during the stall test.
    initial begin
        logic [5:0] pat;
        int         pidx;
        pat  = 6'b101001;
        pidx = 0;
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) begin
                m_if.tready = pat[pidx];
                pidx = (pidx + 1) % 6;
            end else begin
                m_if.tready = 1'b1;
            end
        end
    end

    // Scoreboard: every accepted beat against the model, and hold-while-stalled.
    initial begin
        logic       prev_stall;
        logic [9:0] held;
        logic [9:0] e;
        prev_stall = 1'b0;
        held       = 10'd0;
        forever begin
            @(negedge clk);
            if (prev_stall)
                chk("stall_hold", 128'({m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}), 128'({1'b1, held}));
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_beat: got %0h with nothing expected", m_if.tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("payload", 128'({m_if.tuser, m_if.tlast, m_if.tdata}), 128'(e));
                    pop_cnt++;
                    last_pop = {m_if.tuser, m_if.tlast, m_if.tdata};
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            held       = {m_if.tuser, m_if.tlast, m_if.tdata};
        end
    end

    initial begin
        rx_if.tvalid = 1'b0;
        rx_if.tdata  = 8'd0;
        rx_if.tlast  = 1'b0;
        rx_if.tuser  = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("reset_stream", 128'({m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata, rx_if.tready}), 128'd0);
        chk("reset_regs", 128'({good, drop, src, typ}), 128'd0);
        #24 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 128'(rx_if.tready), 128'd1);

        // Unicast ramp 0x01..0x64
        mk(MY_A, SA1, 16'h0800, 100, 8'h01);
        model_frame(1'b1, 1'b0); send(1'b0, -1); drain();
        check_state("t1");
        chk("t1_good_lit", 128'(good), 128'd1);
        chk("t1_src_lit", 128'(src), 128'h985aebdb066f);
        chk("t1_beats_lit", 128'(pop_cnt), 128'd100);
        chk("t1_last_lit", 128'(last_pop), 128'h164);

        // Foreign DA, 60-byte frame
        mk(FOREIGN, SA1, 16'h0800, 46, 8'h00);
        rdy_low = 0;
        model_frame(1'b1, 1'b0); send(1'b0, -1); drain();
        check_state("t2");
        chk("t2_drop_lit", 128'(drop), 128'd1);
        chk("t2_ready_lit", 128'(rdy_low), 128'd0);
        chk("t2_beats_lit", 128'(pop_cnt), 128'd100);

        // Errored frame: payload emitted, tuser on tlast, good unchanged
        mk(MY_A, SA2, 16'h0800, 20, 8'h80);
        model_frame(1'b1, 1'b1); send(1'b1, -1); drain();
        check_state("t3");
        chk("t3_good_lit", 128'(good), 128'd1);
        chk("t3_last_lit", 128'(last_pop), 128'h393);

        // 500-byte payload under downstream back-pressure
        tog_en = 1'b1;
        mk(MY_A, SA1, 16'h0800, 500, 8'h00);
        model_frame(1'b1, 1'b0); send(1'b0, -1); drain();
        tog_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("t4");
        chk("t4_beats_lit", 128'(pop_cnt), 128'd620);

        // 10-byte runt, header-only frame, then a good frame
        mk(MY_A, SA1, 16'h0800, 0, 8'h00);
        while (fr_q.size() > 10) void'(fr_q.pop_back());
        model_frame(1'b1, 1'b0); send(1'b0, -1);
        mk(MY_A, SA1, 16'h0800, 0, 8'h00);
        model_frame(1'b1, 1'b0); send(1'b0, -1);
        drain();
        chk("t5_beats_lit", 128'(pop_cnt), 128'd620);
        mk(MY_A, SA2, 16'h0800, 8, 8'h10);
        model_frame(1'b1, 1'b0); send(1'b0, -1); drain();
        check_state("t5");
        chk("t5_drop_lit", 128'(drop), 128'd3);
        chk("t5_good_lit", 128'(good), 128'd3);

        // Broadcast accepted, wrong EtherType dropped, disabled frame dropped
        mk(BCAST, SA1, 16'h0800, 5, 8'hc0);
        model_frame(1'b1, 1'b0); send(1'b0, -1); drain();
        mk(MY_A, SA2, 16'h86dd, 5, 8'h00);
        model_frame(1'b1, 1'b0); send(1'b0, -1); drain();
        en = 1'b0;
        mk(MY_A, SA2, 16'h0800, 5, 8'h00);
        model_frame(1'b0, 1'b0); send(1'b0, -1); drain();
        en = 1'b1;
        check_state("t6");
        chk("t6_good_lit", 128'(good), 128'd4);
        chk("t6_drop_lit", 128'(drop), 128'd5);
        chk("t6_src_lit", 128'(src), 128'h985aebdb066f);

        // Reset at payload byte 50 of 200, then a fresh frame
        mk(MY_A, SA1, 16'h0800, 200, 8'h00);
        model_frame(1'b1, 1'b0); send(1'b0, 14 + 50); drain();
        mk(MY_A, SA2, 16'h0800, 30, 8'h40);
        model_frame(1'b1, 1'b0); send(1'b0, -1); drain();
        check_state("t7");
        chk("t7_good_lit", 128'(good), 128'd1);
        chk("t7_drop_lit", 128'(drop), 128'd0);
        chk("t7_src_lit", 128'(src), 128'h0a1b2c3d4e5f);

`ifdef VLAN_STRIP_EN
        // Tagged frame, TCI 0x0002, inner type 0x0800
        mk(MY_A, SA1, 16'h8100, 0, 8'h00);
        fr_q.push_back(8'h00); fr_q.push_back(8'h02);
        fr_q.push_back(8'h08); fr_q.push_back(8'h00);
        for (int i = 0; i < 10; i++) fr_q.push_back(8'h21 + 8'(i));
        model_frame(1'b1, 1'b0); send(1'b0, -1); drain();
        check_state("vlan");
        chk("vlan_id", 128'(vid), 128'(m_vid));
        chk("vlan_id_lit", 128'(vid), 128'h002);
        chk("vlan_last_lit", 128'(last_pop), 128'h12a);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
